// File: rtl/ula_pkg.sv
// Shared ULA encodings: decoder operating modes and sequencer states.
package ula_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT    = 2'b00,
        MODE_SCAN_UP   = 2'b01,
        MODE_SCAN_DOWN = 2'b10,
        MODE_HOLD      = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

endpackage

// File: rtl/onehot_dec.sv
// Combinational SEL_W -> 2**SEL_W one-hot decoder with enable; all-zero when disabled.
module onehot_dec #(
    parameter int unsigned SEL_W = 3
) (
    input  logic                  en,
    input  logic [SEL_W-1:0]      sel,
    output logic [2**SEL_W-1:0]   d
);

    always_comb begin
        d = '0;
        if (en) begin
            d[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered one-hot decoder with direct, scan-up/down and hold modes.
// Define DEC_WRAP_FLAG_EN to add the wrap pulse output.
module onehot_decoder_seq
    import ula_pkg::*;
#(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned RST_IDX = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  step,
    output logic [2**SEL_W-1:0]   d,
    output logic [SEL_W-1:0]      idx,
`ifdef DEC_WRAP_FLAG_EN
    output logic                  wrap,
`endif
    output logic                  active
);

    localparam int unsigned N_OUT = 2**SEL_W;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [N_OUT-1:0]   d_q, d_d;
    mode_e              mode_m;

    assign mode_m = mode_e'(mode);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            unique case (mode_m)
                MODE_DIRECT: begin
                    idx_d   = sel;
                    state_d = ST_ACTIVE;
                end
                MODE_SCAN_UP, MODE_SCAN_DOWN: begin
                    if (state_q == ST_IDLE) begin
                        idx_d   = sel;
                        state_d = ST_ACTIVE;
                    end else if (step) begin
                        // SEL_W-bit arithmetic wraps naturally modulo N_OUT
                        idx_d = (mode_m == MODE_SCAN_UP) ? idx_q + 1'b1 : idx_q - 1'b1;
                    end
                end
                MODE_HOLD: begin
                end
                default: begin
                end
            endcase
        end
    end

    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_dec (
        .en  (state_d == ST_ACTIVE),
        .sel (idx_d),
        .d   (d_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= SEL_W'(RST_IDX);
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            d_q     <= d_d;
        end
    end

    assign d      = d_q;
    assign idx    = idx_q;
    assign active = (state_q == ST_ACTIVE);

`ifdef DEC_WRAP_FLAG_EN
    logic wrap_d, wrap_q;

    // Only a step taken while already active can wrap; loads never do.
    always_comb begin
        wrap_d = 1'b0;
        if (en && state_q == ST_ACTIVE && step) begin
            if (mode_m == MODE_SCAN_UP) begin
                wrap_d = (idx_q == {SEL_W{1'b1}});
            end else if (mode_m == MODE_SCAN_DOWN) begin
                wrap_d = (idx_q == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;
`endif

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Self-checking bench for onehot_decoder_seq: SEL_W=3 (RST_IDX=2) and SEL_W=1 instances.
module tb_onehot_decoder_seq;

    localparam int RST0 = 2;
    localparam logic [1:0] DIR = 2'b00, UP = 2'b01, DN = 2'b10, HLD = 2'b11;

    logic       clk = 1'b0;
    logic       rst, en, step;
    logic [1:0] mode;
    logic [2:0] sel;
    logic [7:0] d;
    logic [2:0] idx;
    logic       active, wrap;
    logic [1:0] d1;
    logic [0:0] idx1;
    logic       active1, wrap1;

    int checks = 0;
    int errors = 0;

    // reference model state
    int   m_idx = 0, m1_idx = 0;
    bit   m_act = 0, m1_act = 0, m_wrap = 0, m1_wrap = 0;
    logic [7:0] exp_d;
    logic [1:0] exp_d1;

    always #5 clk = ~clk;

    onehot_decoder_seq #(.SEL_W(3), .RST_IDX(RST0)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
        .sel    (sel),
        .step   (step),
        .d      (d),
        .idx    (idx),
`ifdef DEC_WRAP_FLAG_EN
        .wrap   (wrap),
`endif
        .active (active)
    );

    onehot_decoder_seq #(.SEL_W(1), .RST_IDX(0)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
        .sel    (sel[0:0]),
        .step   (step),
        .d      (d1),
        .idx    (idx1),
`ifdef DEC_WRAP_FLAG_EN
        .wrap   (wrap1),
`endif
        .active (active1)
    );

`ifndef DEC_WRAP_FLAG_EN
    assign wrap  = 1'b0;
    assign wrap1 = 1'b0;
`endif

    // Behavioural model: integer index arithmetic modulo n.
    function automatic void model(input bit r, input bit e, input int md, input int s,
                                  input bit st, input int n, input int rst_idx,
                                  inout int m_i, inout bit m_a, output bit m_w);
        m_w = 1'b0;
        if (r) begin
            m_i = rst_idx;
            m_a = 1'b0;
        end else if (!e) begin
            m_a = 1'b0;
        end else if (md == 0) begin
            m_i = s;
            m_a = 1'b1;
        end else if (md == 1 || md == 2) begin
            if (!m_a) begin
                m_i = s;
                m_a = 1'b1;
            end else if (st) begin
                if (md == 1) begin
                    m_w = (m_i == n - 1);
                    m_i = (m_i + 1) % n;
                end else begin
                    m_w = (m_i == 0);
                    m_i = (m_i + n - 1) % n;
                end
            end
        end
    endfunction

    task automatic tick(input bit r, input bit e, input logic [1:0] md, input logic [2:0] s,
                        input bit st);
        rst  = r;
        en   = e;
        mode = md;
        sel  = s;
        step = st;
        model(r, e, int'(md), int'(s), st, 8, RST0, m_idx, m_act, m_wrap);
        model(r, e, int'(md), int'(s[0]), st, 2, 0, m1_idx, m1_act, m1_wrap);
        @(posedge clk);
        #1;
        exp_d  = m_act ? (8'd1 << m_idx) : 8'd0;
        exp_d1 = m1_act ? (2'd1 << m1_idx) : 2'd0;
    endtask

    task automatic test_reset();
        tick(1, 1, UP, 3'd5, 1);
        checks++;
        if ({active, idx, d} !== {1'b0, 3'(RST0), 8'h00}) begin
            errors++;
            $display("FAIL reset: got act=%b idx=%0d d=%h, want act=0 idx=%0d d=00",
                     active, idx, d, RST0);
        end
        checks++;
        if (wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_wrap: got %b want 0", wrap);
        end
    endtask

    task automatic test_direct();
        tick(0, 1, DIR, 3'd5, 0);
        checks++;
        if ({active, idx, d} !== {1'b1, 3'd5, 8'b0010_0000}) begin
            errors++;
            $display("FAIL direct_sel5: got act=%b idx=%0d d=%h, want act=1 idx=5 d=20",
                     active, idx, d);
        end
        tick(0, 0, DIR, 3'd2, 1);
        checks++;
        if ({active, idx, d} !== {1'b0, 3'd5, 8'h00}) begin
            errors++;
            $display("FAIL direct_en0: got act=%b idx=%0d d=%h, want act=0 idx=5 d=00",
                     active, idx, d);
        end
    endtask

    task automatic test_scan_up();
        logic [7:0] seq [4];
        seq[0] = 8'h40; seq[1] = 8'h80; seq[2] = 8'h01; seq[3] = 8'h02;
        tick(0, 0, UP, 3'd0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, UP, 3'd6, 1);
            checks++;
            if (d !== seq[i] || d !== exp_d || idx !== m_idx[2:0] || active !== m_act) begin
                errors++;
                $display("FAIL scan_up[%0d]: got d=%h idx=%0d act=%b, want d=%h idx=%0d act=%b",
                         i, d, idx, active, seq[i], m_idx, m_act);
            end
`ifdef DEC_WRAP_FLAG_EN
            checks++;
            if (wrap !== (i == 2)) begin
                errors++;
                $display("FAIL scan_up_wrap[%0d]: got %b want %b", i, wrap, i == 2);
            end
`endif
        end
    endtask

    task automatic test_scan_down();
        tick(0, 1, DIR, 3'd1, 0);
        for (int i = 0; i < 5; i++) begin
            tick(0, 1, DN, 3'd4, (i < 2));
            checks++;
            if ({active, idx, d} !== {m_act, m_idx[2:0], exp_d}) begin
                errors++;
                $display("FAIL scan_down[%0d]: got act=%b idx=%0d d=%h, want act=%b idx=%0d d=%h",
                         i, active, idx, d, m_act, m_idx, exp_d);
            end
            checks++;
            if (i >= 1 && d !== 8'h80) begin
                errors++;
                $display("FAIL scan_down_hold[%0d]: got d=%h want 80", i, d);
            end
`ifdef DEC_WRAP_FLAG_EN
            checks++;
            if (wrap !== (i == 1)) begin
                errors++;
                $display("FAIL scan_down_wrap[%0d]: got %b want %b", i, wrap, i == 1);
            end
`endif
        end
    endtask

    task automatic test_hold();
        tick(0, 1, DIR, 3'd3, 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, HLD, 3'($urandom_range(0, 7)), 1'($urandom));
            checks++;
            if ({active, idx, d} !== {1'b1, 3'd3, 8'h08}) begin
                errors++;
                $display("FAIL hold_active[%0d]: got act=%b idx=%0d d=%h, want act=1 idx=3 d=08",
                         i, active, idx, d);
            end
        end
        tick(0, 0, HLD, 3'd0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, HLD, 3'($urandom_range(0, 7)), 1'($urandom));
            checks++;
            if ({active, d} !== {1'b0, 8'h00}) begin
                errors++;
                $display("FAIL hold_idle[%0d]: got act=%b d=%h, want act=0 d=00", i, active, d);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        tick(0, 1, DIR, 3'd7, 0);
        tick(0, 1, UP, 3'd0, 1);
        tick(1, 1, UP, 3'd4, 1);
        checks++;
        if ({active, idx, d, wrap} !== {1'b0, 3'(RST0), 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_scan: got act=%b idx=%0d d=%h wrap=%b, want act=0 idx=%0d d=00 wrap=0",
                     active, idx, d, wrap, RST0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0),
                 2'($urandom), 3'($urandom), 1'($urandom));
            checks++;
            if ({active, idx, d} !== {m_act, m_idx[2:0], exp_d}) begin
                errors++;
                $display("FAIL random[%0d]: got act=%b idx=%0d d=%h, want act=%b idx=%0d d=%h",
                         i, active, idx, d, m_act, m_idx, exp_d);
            end
            checks++;
            if ($countones(d) > 1) begin
                errors++;
                $display("FAIL onehot[%0d]: got d=%h want at most one bit set", i, d);
            end
`ifdef DEC_WRAP_FLAG_EN
            checks++;
            if (wrap !== m_wrap) begin
                errors++;
                $display("FAIL random_wrap[%0d]: got %b want %b", i, wrap, m_wrap);
            end
`endif
        end
    endtask

    task automatic test_sel_w1();
        logic [1:0] seq [4];
        seq[0] = 2'b10; seq[1] = 2'b01; seq[2] = 2'b10; seq[3] = 2'b01;
        tick(1, 0, DIR, 3'd0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, UP, 3'd1, 1);
            checks++;
            if (d1 !== seq[i] || d1 !== exp_d1 || idx1 !== 1'(m1_idx) || active1 !== 1'b1) begin
                errors++;
                $display("FAIL sel_w1[%0d]: got d=%b idx=%0d act=%b, want d=%b idx=%0d act=1",
                         i, d1, idx1, active1, seq[i], m1_idx);
            end
`ifdef DEC_WRAP_FLAG_EN
            checks++;
            if (wrap1 !== m1_wrap || wrap1 !== (i == 1 || i == 3)) begin
                errors++;
                $display("FAIL sel_w1_wrap[%0d]: got %b want %b", i, wrap1, m1_wrap);
            end
`endif
        end
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        mode = DIR;
        sel  = '0;
        step = 1'b0;
        test_reset();
        test_direct();
        test_scan_up();
        test_scan_down();
        test_hold();
        test_reset_mid_scan();
        test_random();
        test_sel_w1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
